sseg_scan_decoder: RTL

//  Listens to a time-multiplexed 7-segment display bus (anode enables + active-low segments).

---
 rtl/sseg_scan_decoder.sv | 129 ++++++++++++
 1 files changed

// File: rtl/sseg_scan_decoder.sv
// Monitors a multiplexed 7-segment bus and recovers each digit's hex value.
// A digit is captured once its anode/segment pattern has been stable long enough.
module sseg_scan_decoder #(
  parameter int N_DIGITS      = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_DIGITS-1:0]   an,
  input  logic [7:0]            sseg,
  output logic [4*N_DIGITS-1:0] hex_out,
  output logic [N_DIGITS-1:0]   dp_out,
  output logic [N_DIGITS-1:0]   valid_out,
  output logic [N_DIGITS-1:0]   blank_out,
  output logic                  upd,
  output logic [2:0]            upd_idx,
  output logic [7:0]            err_cnt
);

  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  typedef struct packed {
    logic       match;
    logic       blank;
    logic [3:0] hex;
  } decode_t;

  function automatic decode_t decode_seg(input logic [6:0] seg);
    decode_t d;
    d = '{match: 1'b1, blank: 1'b0, hex: 4'h0};
    case (seg)
      7'b1000000: d.hex = 4'h0;
      7'b1111001: d.hex = 4'h1;
      7'b0100100: d.hex = 4'h2;
      7'b0110000: d.hex = 4'h3;
      7'b0011001: d.hex = 4'h4;
      7'b0010010: d.hex = 4'h5;
      7'b0000010: d.hex = 4'h6;
      7'b1111000: d.hex = 4'h7;
      7'b0000000: d.hex = 4'h8;
      7'b0010000: d.hex = 4'h9;
      7'b0001000: d.hex = 4'hA;
      7'b0000011: d.hex = 4'hB;
      7'b1000110: d.hex = 4'hC;
      7'b0100001: d.hex = 4'hD;
      7'b0000110: d.hex = 4'hE;
      7'b0001110: d.hex = 4'hF;
      7'b1111111: begin
        d.match = 1'b0;
        d.blank = 1'b1;
      end
      default: d.match = 1'b0;
    endcase
    return d;
  endfunction

  logic [N_DIGITS-1:0] s_an;
  logic [7:0]          s_sseg;
  logic [CW-1:0]       cnt;
  logic                done;

  logic [N_DIGITS-1:0] an_low;
  logic                in_eq;
  logic                one_low;
  logic                capture;
  logic [2:0]          cap_idx;
  decode_t             dec;

  always_comb begin
    an_low  = ~s_an;
    in_eq   = (an == s_an) && (sseg == s_sseg);
    // Exactly one anode low: non-zero and a power of two after inversion.
    one_low = (an_low != '0) && ((an_low & (an_low - N_DIGITS'(1))) == '0);
    capture = in_eq && (cnt == CNT_MAX) && !done && one_low;
    dec     = decode_seg(s_sseg[6:0]);
    cap_idx = 3'd0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (an_low[i]) cap_idx = 3'(i);
    end
  end

  // NOTE: every register here, including the per-digit result bits, is cleared
  // by reset so the MMIO view is deterministic from the first cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_an      <= '1;
      s_sseg    <= 8'hFF;
      cnt       <= '0;
      done      <= 1'b0;
      hex_out   <= '0;
      dp_out    <= '0;
      valid_out <= '0;
      blank_out <= '0;
      upd       <= 1'b0;
      upd_idx   <= 3'd0;
      err_cnt   <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments so every read above sees pre-edge values.
      upd <= 1'b0;
      if (!in_eq) begin
        s_an   <= an;
        s_sseg <= sseg;
        cnt    <= '0;
        done   <= 1'b0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CW'(1);
      end

      if (capture) begin
        done    <= 1'b1;
        upd     <= 1'b1;
        upd_idx <= cap_idx;
        if (!dec.match && !dec.blank && err_cnt != 8'hFF) begin
          err_cnt <= err_cnt + 8'd1;
        end
        for (int i = 0; i < N_DIGITS; i++) begin
          if (cap_idx == 3'(i)) begin
            hex_out[4*i +: 4] <= dec.hex;
            dp_out[i]         <= ~s_sseg[7];
            valid_out[i]      <= dec.match;
            blank_out[i]      <= dec.blank;
          end
        end
      end
    end
  end

endmodule
